// File: rtl/ctrl_decode_fsm_pkg.sv
// Shared opcodes, FSM states, PC/stack encodings and the registered control-word layout
// for the instruction-side decode controller.
package ctrl_decode_fsm_pkg;

  localparam int OP_W   = 5;
  localparam int DATA_W = 16;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NOP  = 5'd0,  OP_NOT  = 5'd1,  OP_SETC = 5'd2,  OP_CLRC  = 5'd3;
  localparam op_t OP_INC  = 5'd4,  OP_DEC  = 5'd5,  OP_OUT  = 5'd6,  OP_IN    = 5'd7;
  localparam op_t OP_MOV  = 5'd8,  OP_ADD  = 5'd9,  OP_SUB  = 5'd10, OP_AND   = 5'd11;
  localparam op_t OP_OR   = 5'd12, OP_SHL  = 5'd13, OP_SHR  = 5'd14, OP_PUSH  = 5'd15;
  localparam op_t OP_POP  = 5'd16, OP_LDM  = 5'd17, OP_LDD  = 5'd18, OP_STD   = 5'd19;
  localparam op_t OP_JZ   = 5'd20, OP_JN   = 5'd21, OP_JC   = 5'd22, OP_JMP   = 5'd23;
  localparam op_t OP_CALL = 5'd24, OP_RET  = 5'd25, OP_RTI  = 5'd26, OP_RESET = 5'd27;
  localparam op_t OP_INT  = 5'd28;

  typedef enum logic [3:0] {
    RST_S, DECODE, IMM, BRANCH, CALL2, RET2, RTI2, INT1, INT2
  } state_t;

  localparam logic [1:0] PC_INC = 2'd0, PC_RD = 2'd1, PC_STACK = 2'd2, PC_VEC = 2'd3;
  localparam logic [1:0] SP_NONE = 2'd0, SP_PUSH = 2'd1, SP_POP = 2'd2;

  typedef struct packed {
    op_t               alu_op;
    logic [2:0]        rs_sel;
    logic [2:0]        rd_sel;
    logic [DATA_W-1:0] imm;
    logic              imm_valid;
    logic              pc_load;
    logic [1:0]        pc_src;
    logic              vec_sel;
    logic [1:0]        sp_op;
    logic              ccr_save;
    logic              ccr_restore;
    logic              flush;
    logic              int_ack;
  } ctrl_out_t;

  function automatic logic is_two_word(op_t op);
    return op inside {OP_SHL, OP_SHR, OP_LDM, OP_LDD, OP_STD};
  endfunction

endpackage

// File: rtl/ctrl_decode_fsm_if.sv
// Fetch/ALU-facing bundle of the decode controller; master = fetch/datapath side,
// slave = the controller.
interface ctrl_decode_fsm_if;
  import ctrl_decode_fsm_pkg::*;

  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic              instr_ready;
  logic              stall;
  logic              int_req;
  logic              jump_taken;
  logic [OP_W-1:0]   alu_op;
  logic [2:0]        rs_sel;
  logic [2:0]        rd_sel;
  logic [DATA_W-1:0] imm;
  logic              imm_valid;
  logic              pc_load;
  logic [1:0]        pc_src;
  logic              vec_sel;
  logic [1:0]        sp_op;
  logic              ccr_save;
  logic              ccr_restore;
  logic              flush;
  logic              int_ack;

  modport master (
    output instr_valid, instr, stall, int_req, jump_taken,
    input  instr_ready, alu_op, rs_sel, rd_sel, imm, imm_valid, pc_load, pc_src,
           vec_sel, sp_op, ccr_save, ccr_restore, flush, int_ack
  );

  modport slave (
    input  instr_valid, instr, stall, int_req, jump_taken,
    output instr_ready, alu_op, rs_sel, rd_sel, imm, imm_valid, pc_load, pc_src,
           vec_sel, sp_op, ccr_save, ccr_restore, flush, int_ack
  );

endinterface

// File: rtl/ctrl_decode_fsm_instr_class.sv
// Combinational opcode classifier: two-word, conditional branch, control-flow and
// plain one-word ALU ops. Opcodes 0 and 29-31 fall in no class and behave as NOP.
module ctrl_decode_fsm_instr_class
  import ctrl_decode_fsm_pkg::*;
(
  input  op_t  op,
  output logic two_word,
  output logic cond_branch,
  output logic flow,
  output logic alu_only
);

  always_comb begin
    two_word    = is_two_word(op);
    cond_branch = op inside {OP_JZ, OP_JN, OP_JC};
    flow        = op inside {[OP_JMP:OP_INT]};
    alu_only    = (op >= OP_NOT) && (op <= OP_STD) && !is_two_word(op);
  end

endmodule

// File: rtl/ctrl_decode_fsm.sv
// Decode/sequencing controller: accepts fetch words, issues registered ALU ops and
// PC/stack/flag strobes one cycle after the deciding state; stall freezes everything.
module ctrl_decode_fsm
  import ctrl_decode_fsm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  ctrl_decode_fsm_if.slave bus
);

  state_t     state, state_nxt;
  ctrl_out_t  out_q, out_nxt;
  op_t        pend_op;
  logic [2:0] pend_rs, pend_rd;
  op_t        op;
  logic [2:0] rs, rd;
  logic       two_word, cond_branch, flow, alu_only;
  logic       ready, accept;
  logic       unused_lo;

  assign op        = bus.instr[15:11];
  assign rs        = bus.instr[10:8];
  assign rd        = bus.instr[7:5];
  assign unused_lo = ^bus.instr[4:0];

  ctrl_decode_fsm_instr_class u_class (
    .op          (op),
    .two_word    (two_word),
    .cond_branch (cond_branch),
    .flow        (flow),
    .alu_only    (alu_only)
  );

  // A pending interrupt holds the word back in DECODE; IMM always finishes its pair.
  assign ready  = !bus.stall && ((state == DECODE && !bus.int_req) || state == IMM);
  assign accept = ready && bus.instr_valid;
  assign bus.instr_ready = ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RST_S;
      out_q   <= '0;
      pend_op <= '0;
      pend_rs <= '0;
      pend_rd <= '0;
    end else if (!bus.stall) begin
      state <= state_nxt;
      out_q <= out_nxt;
      if (accept && state == DECODE) begin
        pend_op <= op;
        pend_rs <= rs;
        pend_rd <= rd;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RST_S:  state_nxt = DECODE;
      DECODE: begin
        if (bus.int_req) begin
          state_nxt = INT1;
        end else if (accept) begin
          if (two_word)         state_nxt = IMM;
          else if (cond_branch) state_nxt = BRANCH;
          else if (flow) begin
            case (op)
              OP_CALL:  state_nxt = CALL2;
              OP_RET:   state_nxt = RET2;
              OP_RTI:   state_nxt = RTI2;
              OP_RESET: state_nxt = RST_S;
              OP_INT:   state_nxt = INT1;
              default:  state_nxt = DECODE;
            endcase
          end
        end
      end
      IMM:     if (accept) state_nxt = DECODE;
      RTI2:    state_nxt = bus.int_req ? INT1 : DECODE;
      INT1:    state_nxt = INT2;
      default: state_nxt = DECODE;
    endcase
  end

  // rd_sel rides along with every PC_RD load so the datapath can read the target.
  always_comb begin
    out_nxt = '0;
    unique case (state)
      RST_S: begin
        out_nxt.pc_load = 1'b1;
        out_nxt.pc_src  = PC_VEC;
        out_nxt.flush   = 1'b1;
      end
      DECODE: begin
        if (accept) begin
          if (alu_only || cond_branch) begin
            out_nxt.alu_op = op;
            out_nxt.rs_sel = rs;
            out_nxt.rd_sel = rd;
          end else if (op == OP_JMP) begin
            out_nxt.pc_load = 1'b1;
            out_nxt.pc_src  = PC_RD;
            out_nxt.rd_sel  = rd;
            out_nxt.flush   = 1'b1;
          end else if (op == OP_CALL) begin
            out_nxt.alu_op = OP_PUSH;
            out_nxt.sp_op  = SP_PUSH;
          end else if (op == OP_RET || op == OP_RTI) begin
            out_nxt.sp_op = SP_POP;
          end
        end
      end
      IMM: begin
        if (accept) begin
          out_nxt.alu_op    = pend_op;
          out_nxt.rs_sel    = pend_rs;
          out_nxt.rd_sel    = pend_rd;
          out_nxt.imm       = bus.instr;
          out_nxt.imm_valid = 1'b1;
        end
      end
      BRANCH, CALL2: begin
        if (state == CALL2 || bus.jump_taken) begin
          out_nxt.pc_load = 1'b1;
          out_nxt.pc_src  = PC_RD;
          out_nxt.rd_sel  = pend_rd;
          out_nxt.flush   = 1'b1;
        end
      end
      RET2, RTI2: begin
        out_nxt.pc_load     = 1'b1;
        out_nxt.pc_src      = PC_STACK;
        out_nxt.flush       = 1'b1;
        out_nxt.ccr_restore = (state == RTI2);
      end
      INT1: begin
        out_nxt.alu_op   = OP_PUSH;
        out_nxt.sp_op    = SP_PUSH;
        out_nxt.ccr_save = 1'b1;
        out_nxt.int_ack  = 1'b1;
      end
      INT2: begin
        out_nxt.pc_load = 1'b1;
        out_nxt.pc_src  = PC_VEC;
        out_nxt.vec_sel = 1'b1;
        out_nxt.flush   = 1'b1;
      end
      default: out_nxt = '0;
    endcase
  end

  assign bus.alu_op      = out_q.alu_op;
  assign bus.rs_sel      = out_q.rs_sel;
  assign bus.rd_sel      = out_q.rd_sel;
  assign bus.imm         = out_q.imm;
  assign bus.imm_valid   = out_q.imm_valid;
  assign bus.pc_load     = out_q.pc_load;
  assign bus.pc_src      = out_q.pc_src;
  assign bus.vec_sel     = out_q.vec_sel;
  assign bus.sp_op       = out_q.sp_op;
  assign bus.ccr_save    = out_q.ccr_save;
  assign bus.ccr_restore = out_q.ccr_restore;
  assign bus.flush       = out_q.flush;
  assign bus.int_ack     = out_q.int_ack;

endmodule

// File: tb/tb_ctrl_decode_fsm.sv
// Directed vector table plus randomized run against a schedule-queue reference model.
module tb_ctrl_decode_fsm;
  import ctrl_decode_fsm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_decode_fsm_if bus();
  ctrl_decode_fsm dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_vec = 0;
  int n_err = 0;

  localparam ctrl_out_t ZERO = '0;

  typedef struct {
    logic        valid;
    logic [15:0] instr;
    logic        int_req;
    logic        jt;
    logic        stall;
    logic        rdy;
    ctrl_out_t   out;
  } vec_t;

  vec_t tbl[$];

  function automatic ctrl_out_t r_issue(op_t op, logic [2:0] rs, logic [2:0] rd,
                                        logic [15:0] imm, logic iv);
    ctrl_out_t r = '0;
    r.alu_op = op; r.rs_sel = rs; r.rd_sel = rd; r.imm = imm; r.imm_valid = iv;
    return r;
  endfunction

  function automatic ctrl_out_t r_load(logic [1:0] src, logic [2:0] rd, logic vec, logic rest);
    ctrl_out_t r = '0;
    r.pc_load = 1'b1; r.pc_src = src; r.rd_sel = rd; r.vec_sel = vec;
    r.flush = 1'b1; r.ccr_restore = rest;
    return r;
  endfunction

  function automatic ctrl_out_t r_push(logic intr);
    ctrl_out_t r = '0;
    r.alu_op = 5'd15; r.sp_op = 2'd1; r.ccr_save = intr; r.int_ack = intr;
    return r;
  endfunction

  function automatic ctrl_out_t r_pop();
    ctrl_out_t r = '0;
    r.sp_op = 2'd2;
    return r;
  endfunction

  function automatic void add(logic v, logic [15:0] w, logic ir, logic jt, logic st,
                              logic rdy, ctrl_out_t o);
    vec_t e;
    e.valid = v; e.instr = w; e.int_req = ir; e.jt = jt; e.stall = st; e.rdy = rdy; e.out = o;
    tbl.push_back(e);
  endfunction

  function automatic ctrl_out_t dut_out();
    ctrl_out_t r;
    r.alu_op = bus.alu_op; r.rs_sel = bus.rs_sel; r.rd_sel = bus.rd_sel;
    r.imm = bus.imm; r.imm_valid = bus.imm_valid; r.pc_load = bus.pc_load;
    r.pc_src = bus.pc_src; r.vec_sel = bus.vec_sel; r.sp_op = bus.sp_op;
    r.ccr_save = bus.ccr_save; r.ccr_restore = bus.ccr_restore;
    r.flush = bus.flush; r.int_ack = bus.int_ack;
    return r;
  endfunction

  task automatic check_out(ctrl_out_t exp, string name);
    ctrl_out_t got = dut_out();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: outputs got %h want %h", name, got, exp);
    end
  endtask

  task automatic check_ready(logic exp, string name);
    n_vec++;
    if (bus.instr_ready !== exp) begin
      n_err++;
      $display("FAIL %s: instr_ready got %b want %b", name, bus.instr_ready, exp);
    end
  endtask

  task automatic drive(logic v, logic [15:0] w, logic ir, logic jt, logic st);
    bus.instr_valid = v; bus.instr = w; bus.int_req = ir; bus.jump_taken = jt; bus.stall = st;
  endtask

  // Reference model: each accepted word schedules the control words of the cycles it
  // occupies; the controller takes a new word only when nothing remains scheduled.
  ctrl_out_t  q[$];
  ctrl_out_t  exp_out;
  bit         br_pend, imm_wait;
  logic [2:0] br_rd, imm_rs, imm_rd;
  op_t        imm_op;

  task automatic model_reset();
    q.delete();
    q.push_back(r_load(2'd3, 3'd0, 1'b0, 1'b0));
    exp_out = ZERO; br_pend = 0; imm_wait = 0;
  endtask

  function automatic logic model_ready(logic ir, logic st);
    return !st && q.size() == 0 && !br_pend && (imm_wait || !ir);
  endfunction

  task automatic model_decode(logic [15:0] w);
    int op = int'(w[15:11]);
    logic [2:0] rs = w[10:8];
    logic [2:0] rd = w[7:5];
    if (op == 13 || op == 14 || op == 17 || op == 18 || op == 19) begin
      imm_wait = 1; imm_op = op_t'(op); imm_rs = rs; imm_rd = rd;
    end else if (op >= 1 && op <= 19) begin
      q.push_back(r_issue(op_t'(op), rs, rd, 16'h0, 1'b0));
    end else if (op >= 20 && op <= 22) begin
      q.push_back(r_issue(op_t'(op), rs, rd, 16'h0, 1'b0));
      br_pend = 1; br_rd = rd;
    end else if (op == 23) begin
      q.push_back(r_load(2'd1, rd, 1'b0, 1'b0));
    end else if (op == 24) begin
      q.push_back(r_push(1'b0)); q.push_back(r_load(2'd1, rd, 1'b0, 1'b0));
    end else if (op == 25 || op == 26) begin
      q.push_back(r_pop()); q.push_back(r_load(2'd2, 3'd0, 1'b0, op == 26));
    end else if (op == 27) begin
      q.push_back(ZERO); q.push_back(r_load(2'd3, 3'd0, 1'b0, 1'b0));
    end else if (op == 28) begin
      q.push_back(ZERO); q.push_back(r_push(1'b1)); q.push_back(r_load(2'd3, 3'd0, 1'b1, 1'b0));
    end
  endtask

  task automatic model_edge(logic v, logic [15:0] w, logic ir, logic jt, logic st);
    bit idle;
    if (st) return;
    idle = (q.size() == 0) && !br_pend;
    if (br_pend) begin
      br_pend = 0;
      if (jt) q.push_back(r_load(2'd1, br_rd, 1'b0, 1'b0));
    end else if (q.size() == 1 && q[0].ccr_restore && ir) begin
      q.push_back(r_push(1'b1)); q.push_back(r_load(2'd3, 3'd0, 1'b1, 1'b0));
    end else if (idle && imm_wait) begin
      if (v) begin
        q.push_back(r_issue(imm_op, imm_rs, imm_rd, w, 1'b1));
        imm_wait = 0;
      end
    end else if (idle && ir) begin
      q.push_back(ZERO); q.push_back(r_push(1'b1)); q.push_back(r_load(2'd3, 3'd0, 1'b1, 1'b0));
    end else if (idle && v) begin
      model_decode(w);
    end
    exp_out = (q.size() != 0) ? q.pop_front() : ZERO;
  endtask

  initial begin
    // valid, instr, int_req, jump_taken, stall | ready, outputs after the edge
    add(0, 16'h0000, 0, 0, 0, 0, r_load(2'd3, 3'd0, 0, 0));          // RST_S
    add(1, 16'h4A40, 0, 0, 0, 1, r_issue(5'd9, 3'd2, 3'd2, 16'h0, 0)); // ADD
    add(1, 16'h8820, 0, 0, 0, 1, ZERO);                               // LDM word 1
    add(1, 16'h1234, 0, 0, 0, 1, r_issue(5'd17, 3'd0, 3'd1, 16'h1234, 1));
    add(1, 16'hA060, 0, 0, 0, 1, r_issue(5'd20, 3'd0, 3'd3, 16'h0, 0)); // JZ
    add(0, 16'h0000, 0, 1, 0, 0, r_load(2'd1, 3'd3, 0, 0));          // taken
    add(1, 16'hA060, 0, 0, 0, 1, r_issue(5'd20, 3'd0, 3'd3, 16'h0, 0));
    add(0, 16'h0000, 0, 0, 0, 0, ZERO);                               // not taken
    add(1, 16'h8820, 0, 0, 0, 1, ZERO);
    add(1, 16'h00FF, 1, 0, 0, 1, r_issue(5'd17, 3'd0, 3'd1, 16'h00FF, 1)); // int deferred
    add(1, 16'h4A40, 1, 0, 0, 0, ZERO);                               // -> INT1
    add(0, 16'h0000, 0, 0, 0, 0, r_push(1'b1));
    add(0, 16'h0000, 0, 0, 0, 0, r_load(2'd3, 3'd0, 1, 0));
    add(1, 16'h4A40, 0, 0, 1, 0, r_load(2'd3, 3'd0, 1, 0));          // stall holds
    add(1, 16'h4A40, 0, 0, 0, 1, r_issue(5'd9, 3'd2, 3'd2, 16'h0, 0));
    add(1, 16'hC0A0, 0, 0, 0, 1, r_push(1'b0));                       // CALL
    add(0, 16'h0000, 0, 0, 1, 0, r_push(1'b0));
    add(0, 16'h0000, 0, 0, 0, 0, r_load(2'd1, 3'd5, 0, 0));
    add(1, 16'hD000, 0, 0, 0, 1, r_pop());                            // RTI
    add(0, 16'h0000, 1, 0, 0, 0, r_load(2'd2, 3'd0, 0, 1));          // RTI2 -> INT1
    add(0, 16'h0000, 0, 0, 0, 0, r_push(1'b1));
    add(0, 16'h0000, 0, 0, 0, 0, r_load(2'd3, 3'd0, 1, 0));
    add(1, 16'hC800, 0, 0, 0, 1, r_pop());                            // RET
    add(0, 16'h0000, 0, 0, 0, 0, r_load(2'd2, 3'd0, 0, 0));
    add(1, 16'hB8E0, 0, 0, 0, 1, r_load(2'd1, 3'd7, 0, 0));          // JMP
    add(1, 16'hF000, 0, 0, 0, 1, ZERO);                               // op 30
    add(1, 16'hD800, 0, 0, 0, 1, ZERO);                               // RESET
    add(1, 16'h4A40, 0, 0, 0, 0, r_load(2'd3, 3'd0, 0, 0));
    add(1, 16'h8820, 0, 0, 0, 1, ZERO);
    add(1, 16'h0000, 1, 0, 0, 1, r_issue(5'd17, 3'd0, 3'd1, 16'h0000, 1));
    add(0, 16'h0000, 1, 0, 0, 0, ZERO);
    add(0, 16'h0000, 0, 0, 0, 0, r_push(1'b1));

    rst = 1'b1;
    drive(0, 16'h0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_out(ZERO, "reset_outputs");
    check_ready(1'b0, "reset_ready");
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].valid, tbl[i].instr, tbl[i].int_req, tbl[i].jt, tbl[i].stall);
      #1;
      check_ready(tbl[i].rdy, $sformatf("tbl_ready[%0d]", i));
      @(posedge clk);
      @(negedge clk);
      check_out(tbl[i].out, $sformatf("tbl_out[%0d]", i));
    end

    // Reset while the interrupt push is on the outputs: everything clears at once.
    rst = 1'b1;
    drive(0, 16'h0, 0, 0, 0);
    #1;
    check_out(ZERO, "rst_mid_int_out");
    check_ready(1'b0, "rst_mid_int_ready");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_ready(1'b0, "rst_s_ready");
    check_out(ZERO, "rst_s_out");
    @(negedge clk);
    check_out(r_load(2'd3, 3'd0, 0, 0), "rst_vector");
    check_ready(1'b1, "rst_then_ready");

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      logic v, ir, jt, st;
      logic [15:0] w;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        #1;
        check_out(ZERO, "rand_async_reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
      end else begin
        v  = ($urandom_range(0, 3) != 0);
        ir = ($urandom_range(0, 7) == 0);
        jt = $urandom_range(0, 1) == 1;
        st = ($urandom_range(0, 5) == 0);
        w  = 16'($urandom);
        drive(v, w, ir, jt, st);
        #1;
        check_ready(model_ready(ir, st), $sformatf("rand_ready[%0d]", c));
        @(posedge clk);
        model_edge(v, w, ir, jt, st);
        @(negedge clk);
        check_out(exp_out, $sformatf("rand_out[%0d]", c));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
